imm_ext_pipe: RTL and testbench

//  Parametrised, pipelined immediate extender for the decode stage. It replaces the

---
 rtl/imm_ext_pkg.sv | 29 ++
 rtl/imm_pipe_slot.sv | 36 +++
 rtl/imm_ext_pipe.sv | 110 +++++++++++
 tb/tb_imm_ext_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types for the decode-stage immediate extender: format codes and entry layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package imm_ext_pkg;

    // Immediate format select. Codes 6 and 7 are illegal and flagged as fmt_err.
    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4,
        FMT_Z = 3'd5
    } imm_fmt_t;

    localparam int ERR_CNT_W = 8;

    // Widest supported entry. Pipelines sized for a narrower XLEN/TAG_W
    // declare their own entry type with the same field order.
    localparam int IMM_W_MAX = 64;
    localparam int TAG_W_MAX = 8;

    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        logic                 fmt_err;
        logic [TAG_W_MAX-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_pipe_slot.sv
// One elastic register stage carrying a valid bit and an opaque entry.
// Latency: 1 cycle per slot.
// Backpressure: loads whenever empty or when the downstream stage advances; holds otherwise.
module imm_pipe_slot
    import imm_ext_pkg::*;
#(
    parameter type entry_t = imm_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   up_vld,
    input  entry_t up_dat,
    input  logic   dn_adv,
    output logic   vld,
    output entry_t dat,
    output logic   adv
);

    // The slot can take a new entry when it is empty or its entry is moving on.
    assign adv = !vld || dn_adv;

    // Stage register: reset beats flush, flush only drops the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (adv) begin
            vld <= up_vld;
            dat <= up_dat;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined I/S/B/J/U/Z immediate extender with pass-through tag and illegal-format counter.
// Latency: STAGES cycles (1..4), one entry per cycle when out_ready stays high.
// Backpressure: valid/ready; stalls hold every stage, in_ready drops once all stages are full.
// Optional flush port enabled by defining IMMEXT_FLUSH_EN.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [24:0]          in_imm,
    input  logic [2:0]           in_imm_src,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef IMMEXT_FLUSH_EN
    input  logic                 flush,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_fmt_err,
    output logic [TAG_W-1:0]     out_tag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Entry layout sized for this instance; same field order as imm_entry_t.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             fmt_err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic             flush_req;
    logic [XLEN-1:0]  ext_imm;
    logic             ext_err;
    logic [5:0]       shamt;
    logic [STAGES:0]  adv;
    logic [STAGES:0]  stg_vld;
    entry_t           stg_dat [STAGES+1];

`ifdef IMMEXT_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Shift amounts are 5 bits wide on RV32 and 6 bits on RV64.
    assign shamt = {(XLEN == 64) ? in_imm[18] : 1'b0, in_imm[17:13]};

    // Extend the raw instruction bits [31:7] according to the selected format.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (in_imm_src)
            FMT_I:   ext_imm = XLEN'($signed(in_imm[24:13]));
            FMT_S:   ext_imm = XLEN'($signed({in_imm[24:18], in_imm[4:0]}));
            FMT_B:   ext_imm = XLEN'($signed({in_imm[24], in_imm[0], in_imm[23:18],
                                              in_imm[4:1], 1'b0}));
            FMT_J:   ext_imm = XLEN'($signed({in_imm[24], in_imm[12:5], in_imm[13],
                                              in_imm[23:14], 1'b0}));
            FMT_U:   ext_imm = XLEN'($signed({in_imm[24:5], 12'b0}));
            FMT_Z:   ext_imm = XLEN'(shamt);
            default: ext_err = 1'b1;
        endcase
    end

    // Stage 0 is fed straight from the inputs; nothing enters during a flush.
    assign stg_vld[0]         = in_valid && !flush_req;
    assign stg_dat[0].imm     = ext_imm;
    assign stg_dat[0].fmt_err = ext_err;
    assign stg_dat[0].tag     = in_tag;
    assign adv[STAGES]        = out_ready;
    assign in_ready           = adv[0] && !flush_req;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        imm_pipe_slot #(
            .entry_t (entry_t)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush_req),
            .up_vld (stg_vld[k]),
            .up_dat (stg_dat[k]),
            .dn_adv (adv[k+1]),
            .vld    (stg_vld[k+1]),
            .dat    (stg_dat[k+1]),
            .adv    (adv[k])
        );
    end

    assign out_valid   = stg_vld[STAGES];
    assign out_imm     = stg_dat[STAGES].imm;
    assign out_fmt_err = stg_dat[STAGES].fmt_err;
    assign out_tag     = stg_dat[STAGES].tag;

    // Count illegal-format entries as they are captured, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (in_valid && in_ready && ext_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: XLEN=32/STAGES=2 and XLEN=64/STAGES=3 instances.
// Latency: not applicable (testbench).
// Backpressure: out_ready of the 32-bit instance is driven by the stimulus; the 64-bit one always accepts.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_valid64;
    logic             out_ready;
    logic [24:0]      in_imm;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
`ifdef IMMEXT_FLUSH_EN
    logic             flush;
`endif

    logic             in_ready,  in_ready64;
    logic             out_valid, out_valid64;
    logic [31:0]      out_imm;
    logic [63:0]      out_imm64;
    logic             out_fmt_err, out_fmt_err64;
    logic [TAG_W-1:0] out_tag, out_tag64;
    logic [7:0]       err_cnt, err_cnt64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .STAGES(2), .TAG_W(TAG_W)) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm      (in_imm),
        .in_imm_src  (in_imm_src),
        .in_tag      (in_tag),
`ifdef IMMEXT_FLUSH_EN
        .flush       (flush),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt_err (out_fmt_err),
        .out_tag     (out_tag),
        .err_cnt     (err_cnt)
    );

    imm_ext_pipe #(.XLEN(64), .STAGES(3), .TAG_W(TAG_W)) u_dut64 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid64),
        .in_ready    (in_ready64),
        .in_imm      (in_imm),
        .in_imm_src  (in_imm_src),
        .in_tag      (in_tag),
`ifdef IMMEXT_FLUSH_EN
        .flush       (flush),
`endif
        .out_valid   (out_valid64),
        .out_ready   (1'b1),
        .out_imm     (out_imm64),
        .out_fmt_err (out_fmt_err64),
        .out_tag     (out_tag64),
        .err_cnt     (err_cnt64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [2:0] src, input logic [31:0] instr, input int tag);
        in_valid   = v;
        in_imm_src = src;
        in_imm     = instr[31:7];
        in_tag     = TAG_W'(tag);
    endtask

    // One isolated entry through the 32-bit instance, checked after STAGES cycles.
    task automatic single(input logic [2:0] src, input logic [31:0] instr, input int tag,
                          input logic [31:0] exp, input string name);
        put(1'b1, src, instr, tag);
        tick();
        put(1'b0, FMT_I, 32'h0, 0);
        tick();
        chk({name, "_vld"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_imm"}, {32'd0, out_imm}, {32'd0, exp});
        chk({name, "_err"}, {63'd0, out_fmt_err}, 64'd0);
        chk({name, "_tag"}, {59'd0, out_tag}, 64'(tag));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int exp_tag;
        int n_out;

        rst        = 1'b1;
        in_valid64 = 1'b0;
        out_ready  = 1'b1;
`ifdef IMMEXT_FLUSH_EN
        flush      = 1'b0;
`endif
        put(1'b0, FMT_I, 32'h0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_vld",   {63'd0, out_valid},   64'd0);
        chk("rst_imm",   {32'd0, out_imm},     64'd0);
        chk("rst_err",   {63'd0, out_fmt_err}, 64'd0);
        chk("rst_tag",   {59'd0, out_tag},     64'd0);
        chk("rst_cnt",   {56'd0, err_cnt},     64'd0);
        chk("rst_rdy",   {63'd0, in_ready},    64'd1);
        chk("rst_vld64", {63'd0, out_valid64}, 64'd0);
        chk("rst_imm64", out_imm64,            64'd0);

        // I-format, latency exactly two cycles
        put(1'b1, FMT_I, 32'hFFF00093, 3);
        tick();
        put(1'b0, FMT_I, 32'h0, 0);
        chk("i_lat1_vld", {63'd0, out_valid}, 64'd0);
        tick();
        chk("i_vld", {63'd0, out_valid}, 64'd1);
        chk("i_imm", {32'd0, out_imm},   64'h0000_0000_FFFF_FFFF);
        chk("i_tag", {59'd0, out_tag},   64'd3);
        tick();
        chk("i_drained", {63'd0, out_valid}, 64'd0);

        // Remaining formats on XLEN=32
        single(FMT_S, 32'h00112623, 1, 32'h0000000C, "s_pos");
        single(FMT_S, 32'hFE112E23, 2, 32'hFFFFFFFC, "s_neg");
        single(FMT_B, 32'hFE000EE3, 4, 32'hFFFFFFFC, "b_neg");
        single(FMT_J, 32'h008000EF, 5, 32'h00000008, "j_pos");
        single(FMT_U, 32'h123450B7, 6, 32'h12345000, "u_pos");
        single(FMT_Z, 32'hFFF09093, 7, 32'h0000001F, "z_32");

        // XLEN=64, three stages: U then Z back to back
        put(1'b0, FMT_U, 32'h800000B7, 9);
        in_valid64 = 1'b1;
        tick();
        put(1'b0, FMT_Z, 32'hFFF09093, 10);
        tick();
        in_valid64 = 1'b0;
        tick();
        chk("u64_vld", {63'd0, out_valid64}, 64'd1);
        chk("u64_imm", out_imm64,            64'hFFFF_FFFF_8000_0000);
        chk("u64_tag", {59'd0, out_tag64},   64'd9);
        tick();
        chk("z64_vld", {63'd0, out_valid64}, 64'd1);
        chk("z64_imm", out_imm64,            64'h0000_0000_0000_003F);
        chk("z64_tag", {59'd0, out_tag64},   64'd10);
        tick();
        chk("z64_drained", {63'd0, out_valid64}, 64'd0);

        // Eight back-to-back entries, out_ready low for cycles 3..6
        nxt     = 0;
        exp_tag = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (nxt < 8) put(1'b1, FMT_I, (nxt << 20) | 32'h13, nxt);
            else         put(1'b0, FMT_I, 32'h0, 0);
            #1;
            if (nxt < 8)
                chk($sformatf("str_rdy_c%0d", cyc), {63'd0, in_ready}, {63'd0, (cyc < 3 || cyc > 6)});
            if (cyc >= 2 && cyc <= 13)
                chk($sformatf("str_vld_c%0d", cyc), {63'd0, out_valid}, 64'd1);
            if (cyc >= 3 && cyc <= 7) begin
                chk($sformatf("str_hold_tag_c%0d", cyc), {59'd0, out_tag}, 64'd1);
                chk($sformatf("str_hold_imm_c%0d", cyc), {32'd0, out_imm}, 64'd1);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("str_tag_c%0d", cyc), {59'd0, out_tag}, 64'(exp_tag));
                chk($sformatf("str_imm_c%0d", cyc), {32'd0, out_imm}, 64'(exp_tag));
                exp_tag++;
            end
            if (in_valid && in_ready) nxt++;
            tick();
        end
        chk("str_count", 64'(exp_tag), 64'd8);

        // 300 illegal-format entries; counter saturates at 255
        out_ready = 1'b1;
        n_out     = 0;
        for (int k = 0; k < 300; k++) begin
            put(1'b1, 3'b111, 32'hDEADBEEF, k);
            if (k == 0 || k == 100 || k == 255 || k == 299)
                chk($sformatf("sat_cnt_k%0d", k), {56'd0, err_cnt}, 64'((k > 255) ? 255 : k));
            if (out_valid) begin
                n_out++;
                chk("sat_imm", {32'd0, out_imm},   64'd0);
                chk("sat_err", {63'd0, out_fmt_err}, 64'd1);
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            put(1'b0, FMT_I, 32'h0, 0);
            if (out_valid) begin
                n_out++;
                chk("sat_imm", {32'd0, out_imm},   64'd0);
                chk("sat_err", {63'd0, out_fmt_err}, 64'd1);
            end
            tick();
        end
        chk("sat_cnt_final", {56'd0, err_cnt}, 64'd255);
        chk("sat_outputs",   64'(n_out),       64'd300);

        // Reset with two entries in flight
        out_ready = 1'b0;
        put(1'b1, FMT_U, 32'h123450B7, 20);
        tick();
        put(1'b1, FMT_U, 32'h123450B7, 21);
        tick();
        put(1'b0, FMT_I, 32'h0, 0);
        chk("mrst_pre_vld", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        tick();
        chk("mrst_vld", {63'd0, out_valid},   64'd0);
        chk("mrst_imm", {32'd0, out_imm},     64'd0);
        chk("mrst_err", {63'd0, out_fmt_err}, 64'd0);
        chk("mrst_tag", {59'd0, out_tag},     64'd0);
        chk("mrst_cnt", {56'd0, err_cnt},     64'd0);
        rst = 1'b0;
        tick();
        chk("mrst_rdy",      {63'd0, in_ready},  64'd1);
        chk("mrst_post_vld", {63'd0, out_valid}, 64'd0);

`ifdef IMMEXT_FLUSH_EN
        // Flush with two entries in flight; flushed entries never surface
        out_ready = 1'b0;
        put(1'b1, FMT_I, 32'h00A00093, 10);
        tick();
        put(1'b1, FMT_I, 32'h00B00093, 11);
        tick();
        chk("fl_pre_vld", {63'd0, out_valid}, 64'd1);
        chk("fl_pre_tag", {59'd0, out_tag},   64'd10);
        flush = 1'b1;
        put(1'b1, 3'b111, 32'h0, 12);
        #1;
        chk("fl_rdy", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        put(1'b0, FMT_I, 32'h0, 0);
        chk("fl_vld", {63'd0, out_valid}, 64'd0);
        chk("fl_cnt", {56'd0, err_cnt},   64'd0);
        out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            tick();
            chk($sformatf("fl_gone_%0d", d), {63'd0, out_valid}, 64'd0);
        end
        put(1'b1, FMT_I, 32'hFFF00093, 13);
        tick();
        put(1'b0, FMT_I, 32'h0, 0);
        tick();
        chk("fl_after_vld", {63'd0, out_valid}, 64'd1);
        chk("fl_after_tag", {59'd0, out_tag},   64'd13);
        chk("fl_after_imm", {32'd0, out_imm},   64'h0000_0000_FFFF_FFFF);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
